// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M iterative divider: widths, op codes, states
// and the conditional two's-complement negate used for sign handling.
package div_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ITER = XLEN;
  localparam int unsigned CntW = $clog2(ITER);

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] DIV_OVF_Q  = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StFin  = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow skip the iteration and finish immediately.
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            rem_sel_q, rem_sel_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;

  logic            is_signed, is_rem, div_zero, ovf;
  logic [XLEN-1:0] a_abs, b_abs, special_res;
  logic [XLEN:0]   rem_shift;
  logic [XLEN+1:0] diff;
  logic            step_ge;
  logic [XLEN-1:0] rem_step, quo_step, fin_sel, fin_res;
  logic            fin_neg;
  logic            unused_diff;

  assign is_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign is_rem    = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  assign div_zero  = (divisor == '0);
  assign ovf       = is_signed && (dividend == DIV_OVF_Q) && (divisor == '1);

  assign a_abs = cond_neg(dividend, is_signed & dividend[XLEN-1]);
  assign b_abs = cond_neg(divisor, is_signed & divisor[XLEN-1]);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = is_rem ? dividend : DIV_ZERO_Q;
    end else if (ovf) begin
      special_res = is_rem ? '0 : DIV_OVF_Q;
    end
  end

  // Remainder stays below the divisor, so the shifted value fits in XLEN+1 bits.
  assign rem_shift   = {rem_q, quo_q[XLEN-1]};
  assign diff        = {1'b0, rem_shift} - {2'b00, dvs_q};
  assign step_ge     = ~diff[XLEN+1];
  assign rem_step    = step_ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_step    = {quo_q[XLEN-2:0], step_ge};
  assign unused_diff = diff[XLEN];

  assign fin_sel = rem_sel_q ? rem_step : quo_step;
  assign fin_neg = rem_sel_q ? r_neg_q : q_neg_q;
  assign fin_res = cond_neg(fin_sel, fin_neg);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    rem_sel_d = rem_sel_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          rem_sel_d = is_rem;
          if (div_zero || ovf) begin
            result_d = special_res;
            state_d  = StFin;
          end else begin
            rem_d   = '0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            q_neg_d = is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_neg_d = is_signed & dividend[XLEN-1];
            cnt_d   = '0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(ITER - 1)) begin
            result_d = fin_res;
            state_d  = StFin;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      rem_sel_q <= rem_sel_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
    end
  end

  assign busy   = (state_q != StIdle);
  // A kill arriving in the final cycle still suppresses the completion pulse.
  assign done   = (state_q == StFin) && !flush;
  assign result = result_q;

endmodule
